// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the core load/store port, the controller and the two data memories.
// cpu_req is held by the core until it sees the one-cycle cpu_done pulse; ext_req is held by the controller until ext_ack or timeout.
interface mem_access_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;

    logic        int_en;
    logic        int_we;
    logic [31:0] int_addr;
    logic [31:0] int_wdata;
    logic [31:0] int_rdata;

    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_err,
        output int_en, int_we, int_addr, int_wdata,
        input  int_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ack
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_err,
        input  int_en, int_we, int_addr, int_wdata,
        output int_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: routes one core load/store at a time to the internal
// synchronous RAM or, inside the external window, through a req/ack handshake with timeout.
module mem_access_ctrl #(
    parameter logic [31:0] EXT_BASE  = 32'h0000_0A00,
    parameter logic [31:0] EXT_LIMIT = 32'h0000_0DFF,
    parameter int          TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_ctrl_if.master    bus,
    output logic [2:0]           dbg_state
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INT      = 3'd1,
        S_INT_WAIT = 3'd2,
        S_EXT      = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic          we_q, done_q, err_q, ext_req_q;
    logic [CW-1:0] cnt;
    logic          ext_hit, timeout_hit;

    assign ext_hit     = (bus.cpu_addr >= EXT_BASE) && (bus.cpu_addr <= EXT_LIMIT);
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     if (bus.cpu_req) state_n = ext_hit ? S_EXT : S_INT;
            S_INT:      state_n = S_INT_WAIT;
            S_INT_WAIT: state_n = S_RESP;
            S_EXT:      if (bus.ext_ack || timeout_hit) state_n = S_RESP;
            S_RESP:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ext_req_q <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cpu_req) begin
                        addr_q    <= bus.cpu_addr;
                        wdata_q   <= bus.cpu_wdata;
                        we_q      <= bus.cpu_we;
                        ext_req_q <= ext_hit;
                    end
                end
                S_INT_WAIT: begin
                    if (!we_q) rdata_q <= bus.int_rdata;
                    done_q <= 1'b1;
                end
                S_EXT: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (bus.ext_ack) begin
                        ext_req_q <= 1'b0;
                        if (!we_q) rdata_q <= bus.ext_rdata;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        cnt       <= '0;
                    end else if (timeout_hit) begin
                        ext_req_q <= 1'b0;
                        rdata_q   <= '0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_done  = done_q;
    assign bus.cpu_err   = err_q;
    assign bus.int_en    = (state == S_INT);
    assign bus.int_we    = (state == S_INT) && we_q;
    assign bus.int_addr  = addr_q;
    assign bus.int_wdata = wdata_q;
    assign bus.ext_req   = ext_req_q;
    assign bus.ext_we    = we_q;
    assign bus.ext_addr  = addr_q;
    assign bus.ext_wdata = wdata_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: internal RAM model plus hand-driven external ack.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();
  logic [2:0] dbg_state;

  mem_access_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  // internal synchronous RAM: read data valid the cycle after int_en
  logic [31:0] ram [0:1023];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h1000_0000 + 32'(i);
      ram[10'h1FF] <= 32'hDEAD_BEEF;
    end else if (bus.int_en) begin
      if (bus.int_we) ram[bus.int_addr[9:0]] <= bus.int_wdata;
      ram_q <= ram[bus.int_addr[9:0]];
    end
  end
  assign bus.int_rdata = ram_q;

  // observations from the last issue() call
  logic        obs_done, obs_err, obs_ext_we, obs_done_after;
  logic [31:0] obs_rdata, obs_ext_wdata;
  logic [2:0]  obs_state_after;
  int          obs_lat, obs_int_cyc, obs_ext_cyc;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction; ack_after = wait cycles before ext_ack (-1 = never ack).
  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ack_after, input logic [31:0] ack_data);
    obs_done = 1'b0; obs_err = 1'b0; obs_lat = 0; obs_int_cyc = 0; obs_ext_cyc = 0;
    obs_ext_we = 1'b0; obs_ext_wdata = '0; obs_rdata = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    bus.ext_ack = 1'b0; bus.ext_rdata = ack_data;
    for (int n = 1; n <= 40 && !obs_done; n++) begin
      tick;
      if (bus.int_en) obs_int_cyc++;
      if (bus.ext_req) begin
        obs_ext_cyc++;
        obs_ext_we = bus.ext_we;
        obs_ext_wdata = bus.ext_wdata;
      end
      bus.ext_ack = (ack_after >= 0 && bus.ext_req && obs_ext_cyc == ack_after + 1) ? 1'b1 : 1'b0;
      if (bus.cpu_done) begin
        obs_done = 1'b1; obs_lat = n; obs_rdata = bus.cpu_rdata; obs_err = bus.cpu_err;
        bus.cpu_req = 1'b0; bus.ext_ack = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    bus.ext_ack = 1'b0;
    tests++;
    if (obs_done !== 1'b1) begin
      fails++;
      $display("FAIL %s no_done: cpu_done never seen within 40 cycles", name);
    end
    tick;
    obs_done_after = bus.cpu_done;
    obs_state_after = dbg_state;
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({bus.cpu_done, bus.cpu_err, bus.int_en, bus.int_we, bus.ext_req, bus.ext_we} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.cpu_done, bus.cpu_err, bus.int_en, bus.int_we, bus.ext_req, bus.ext_we});
    end
    tests++;
    if ({bus.cpu_rdata, bus.int_addr, bus.int_wdata, bus.ext_addr, bus.ext_wdata} !== 160'b0) begin
      fails++; $display("FAIL reset_data: rdata=%h int_addr=%h ext_addr=%h want 0",
        bus.cpu_rdata, bus.int_addr, bus.ext_addr);
    end
    tests++;
    if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    tick;
  endtask

  task automatic test_int_load;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_09FF; bus.cpu_wdata = '0;
    tick;
    tests++;
    if ({bus.int_en, bus.int_we, bus.ext_req, bus.int_addr} !== {3'b100, 32'h0000_09FF}) begin
      fails++; $display("FAIL int_cycle: en=%b we=%b ext_req=%b addr=%h want 1 0 0 000009ff",
        bus.int_en, bus.int_we, bus.ext_req, bus.int_addr);
    end
    tick;
    tests++;
    if ({bus.int_en, bus.cpu_done, bus.ext_req} !== 3'b000) begin
      fails++; $display("FAIL int_wait: en=%b done=%b ext_req=%b want 0 0 0",
        bus.int_en, bus.cpu_done, bus.ext_req);
    end
    tick;
    tests++;
    if ({bus.cpu_done, bus.cpu_err, bus.cpu_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL int_done: done=%b err=%b rdata=%h want 1 0 deadbeef",
        bus.cpu_done, bus.cpu_err, bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    tick;
    tests++;
    if ({bus.cpu_done, dbg_state} !== 4'b0000) begin
      fails++; $display("FAIL int_end: done=%b state=%0d want 0 0", bus.cpu_done, dbg_state);
    end
  endtask

  task automatic test_window;
    logic [31:0] addrs [4];
    logic [31:0] exp_rd [4];
    int          exp_int [4];
    int          exp_lat [4];
    addrs   = '{32'h0000_0A00, 32'h0000_0DFF, 32'h0000_09FF, 32'h0000_0E00};
    exp_rd  = '{32'hE000_0A00, 32'hE000_0DFF, 32'hDEAD_BEEF, 32'h1000_0200};
    exp_int = '{0, 0, 1, 1};
    exp_lat = '{2, 2, 3, 3};
    for (int k = 0; k < 4; k++) begin
      issue("window", 1'b0, addrs[k], '0, 0, 32'hE000_0000 | addrs[k]);
      tests++;
      if (obs_int_cyc !== exp_int[k] || obs_ext_cyc !== 1 - exp_int[k]) begin
        fails++; $display("FAIL window_decode addr=%h: int_cyc=%0d ext_cyc=%0d want %0d %0d",
          addrs[k], obs_int_cyc, obs_ext_cyc, exp_int[k], 1 - exp_int[k]);
      end
      tests++;
      if (obs_rdata !== exp_rd[k] || obs_lat !== exp_lat[k]) begin
        fails++; $display("FAIL window_data addr=%h: rdata=%h lat=%0d want %h %0d",
          addrs[k], obs_rdata, obs_lat, exp_rd[k], exp_lat[k]);
      end
    end
  endtask

  task automatic test_ext;
    issue("ext_load", 1'b0, 32'h0000_0C40, '0, 3, 32'h1234_5678);
    tests++;
    if (obs_ext_cyc !== 4 || obs_lat !== 5 || obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0) begin
      fails++; $display("FAIL ext_load: ext_cyc=%0d lat=%0d rdata=%h err=%b want 4 5 12345678 0",
        obs_ext_cyc, obs_lat, obs_rdata, obs_err);
    end
    tests++;
    if (obs_done_after !== 1'b0 || bus.ext_req !== 1'b0) begin
      fails++; $display("FAIL ext_load_end: done=%b ext_req=%b want 0 0", obs_done_after, bus.ext_req);
    end
    issue("ext_store", 1'b1, 32'h0000_0B00, 32'hCAFE_0001, 1, 32'hFFFF_FFFF);
    tests++;
    if (obs_ext_we !== 1'b1 || obs_ext_wdata !== 32'hCAFE_0001 || obs_ext_cyc !== 2) begin
      fails++; $display("FAIL ext_store: we=%b wdata=%h ext_cyc=%0d want 1 cafe0001 2",
        obs_ext_we, obs_ext_wdata, obs_ext_cyc);
    end
    tests++;
    if (obs_rdata !== 32'h1234_5678) begin
      fails++; $display("FAIL ext_store_rdata: got %h want 12345678", obs_rdata);
    end
  endtask

  task automatic test_timeout;
    issue("timeout", 1'b0, 32'h0000_0C00, '0, -1, 32'h5555_5555);
    tests++;
    if (obs_ext_cyc !== 16 || obs_lat !== 17 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      fails++; $display("FAIL timeout: ext_cyc=%0d lat=%0d err=%b rdata=%h want 16 17 1 0",
        obs_ext_cyc, obs_lat, obs_err, obs_rdata);
    end
    tests++;
    if (obs_done_after !== 1'b0 || bus.cpu_err !== 1'b0) begin
      fails++; $display("FAIL timeout_end: done=%b err=%b want 0 0", obs_done_after, bus.cpu_err);
    end
    issue("ack_last", 1'b0, 32'h0000_0C00, '0, 15, 32'h8765_4321);
    tests++;
    if (obs_ext_cyc !== 16 || obs_err !== 1'b0 || obs_rdata !== 32'h8765_4321) begin
      fails++; $display("FAIL ack_last: ext_cyc=%0d err=%b rdata=%h want 16 0 87654321",
        obs_ext_cyc, obs_err, obs_rdata);
    end
  endtask

  task automatic test_back_to_back;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0300; bus.cpu_wdata = 32'hA5A5_0300;
    tick;
    tick;
    tick;
    tests++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_rdata !== 32'h8765_4321) begin
      fails++; $display("FAIL b2b_first: done=%b rdata=%h want 1 87654321", bus.cpu_done, bus.cpu_rdata);
    end
    bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0100;
    tick;
    tests++;
    if (bus.cpu_done !== 1'b0 || dbg_state !== 3'd0) begin
      fails++; $display("FAIL b2b_idle: done=%b state=%0d want 0 0", bus.cpu_done, dbg_state);
    end
    tick;
    tests++;
    if ({bus.int_en, bus.int_we, bus.int_addr} !== {2'b10, 32'h0000_0100}) begin
      fails++; $display("FAIL b2b_accept: en=%b we=%b addr=%h want 1 0 00000100",
        bus.int_en, bus.int_we, bus.int_addr);
    end
    tick;
    tests++;
    if (bus.cpu_done !== 1'b0) begin fails++; $display("FAIL b2b_wait: done=%b want 0", bus.cpu_done); end
    tick;
    tests++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_rdata !== 32'h1000_0100) begin
      fails++; $display("FAIL b2b_second: done=%b rdata=%h want 1 10000100", bus.cpu_done, bus.cpu_rdata);
    end
    bus.cpu_req = 1'b0;
    tick;
    tests++;
    if (bus.cpu_done !== 1'b0) begin fails++; $display("FAIL b2b_end: done=%b want 0", bus.cpu_done); end
    issue("b2b_readback", 1'b0, 32'h0000_0300, '0, -1, '0);
    tests++;
    if (obs_rdata !== 32'hA5A5_0300) begin
      fails++; $display("FAIL b2b_readback: got %h want a5a50300", obs_rdata);
    end
  endtask

  task automatic test_reset_mid_ext;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0C00; bus.ext_ack = 1'b0;
    tick;
    tests++;
    if (bus.ext_req !== 1'b1) begin fails++; $display("FAIL rst_ext_start: ext_req=%b want 1", bus.ext_req); end
    tick;
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({bus.ext_req, bus.cpu_done, bus.int_en, dbg_state} !== 6'b0 || bus.ext_addr !== 32'h0) begin
      fails++; $display("FAIL rst_async: ext_req=%b done=%b state=%0d addr=%h want 0 0 0 0",
        bus.ext_req, bus.cpu_done, dbg_state, bus.ext_addr);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue("rst_recover", 1'b0, 32'h0000_09FF, '0, -1, '0);
    tests++;
    if (obs_rdata !== 32'hDEAD_BEEF || obs_lat !== 3 || obs_ext_cyc !== 0) begin
      fails++; $display("FAIL rst_recover: rdata=%h lat=%0d ext_cyc=%0d want deadbeef 3 0",
        obs_rdata, obs_lat, obs_ext_cyc);
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_rdata = '0; bus.ext_ack = 1'b0;
    test_reset;
    test_int_load;
    test_window;
    test_ext;
    test_timeout;
    test_back_to_back;
    test_reset_mid_ext;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory access sequencer between the MIPS core's load/store port and the two data memories. Decodes each request against the external window (0x0A00-0x0DFF by default). Internal accesses run with fixed synchronous-RAM timing. External accesses run through a req/ack handshake with a timeout. It returns one completion pulse per transaction to the core.

Parameters:
EXT_BASE, 32'h0000_0A00, first address mapped to external memory (inclusive)
EXT_LIMIT, 32'h0000_0DFF, last address mapped to external memory (inclusive)
TIMEOUT, 16, max cycles spent in EXT waiting for ext_ack; must be >= 1

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  transaction request, held high until cpu_done
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid while cpu_done=1
cpu_done  out  1  one-cycle completion pulse
cpu_err  out  1  high with cpu_done when the external access timed out
int_en  out  1  internal RAM enable
int_we  out  1  internal RAM write enable
int_addr  out  32  internal RAM address
int_wdata  out  32  internal RAM write data
int_rdata  in  32  internal RAM read data, valid 1 cycle after int_en
ext_req  out  1  external request, level, registered
ext_we  out  1  external write enable
ext_addr  out  32  external address
ext_wdata  out  32  external write data
ext_rdata  in  32  external read data, valid when ext_ack=1
ext_ack  in  1  external completion, sampled only in EXT

Behaviour:
- States: IDLE, INT, INT_WAIT, EXT, RESP. Reset enters IDLE.
- Reset values: every output is 0, the latched address, data and we registers are 0, and the timeout counter is 0. Reset is asynchronous, so ext_req falls immediately, including mid-transaction.
- Decode: external if EXT_BASE <= cpu_addr <= EXT_LIMIT, using unsigned 32-bit compares. Both bounds are inclusive. Otherwise internal.
- IDLE: cpu_req is sampled only here. On an edge with cpu_req=1, latch addr, wdata and we.
  - Internal request: go to INT.
  - External request: go to EXT, with ext_req set high on that same edge.
- INT (1 cycle):
  - int_en=1, int_we=latched we.
  - int_addr and int_wdata are driven from the latched values.
  - Go to INT_WAIT.
- INT_WAIT (1 cycle):
  - int_en=0.
  - On the exit edge: if load, cpu_rdata <= int_rdata; then cpu_done <= 1 and go to RESP.
- EXT:
  - ext_req=1; ext_we, ext_addr and ext_wdata are driven from the latched values.
  - The counter increments every cycle spent in EXT.
  - Ack path: on an edge with ext_ack=1, ext_req <= 0; if load, cpu_rdata <= ext_rdata; cpu_done <= 1; cpu_err <= 0; go to RESP.
  - Timeout path: on the edge where the counter reaches TIMEOUT-1 with no ack, ext_req <= 0, cpu_rdata <= 0, cpu_done <= 1, cpu_err <= 1; go to RESP.
  - Ack and timeout on the same edge: ack wins, cpu_err=0.
- RESP (1 cycle): cpu_done=1; go to IDLE and clear cpu_done, cpu_err and the counter.
- Stores leave cpu_rdata unchanged.
- Latency, counted from the acceptance edge E0:
  - Internal: cpu_done is high in the cycle after E2 (3 edges total, to E3 back in IDLE).
  - External: cpu_done is high in the cycle after the ack edge. Minimum case is ack sampled at E1.
- Handshake: the requester must lower cpu_req or present its next transaction in the RESP cycle. If cpu_req is still high at the IDLE edge, it is treated as a new transaction.
- cpu_addr, cpu_we and cpu_wdata changes after E0 are ignored until the next acceptance.
- Only one transaction is in flight at a time. No pipelining.
- ext_ack outside EXT is ignored.
- Counter width: $clog2(TIMEOUT+1). It never wraps because it is cleared on leaving EXT.

Test Plan:
1. Internal load: addr=0x09FF, int_rdata=0xDEADBEEF one cycle after int_en -> int_en for exactly 1 cycle; cpu_done high 1 cycle at E2+, cpu_rdata=0xDEADBEEF, cpu_err=0, ext_req never asserted.
2. Window edges: loads to 0x0A00 and 0x0DFF -> ext_req asserted, int_en stays 0. Loads to 0x09FF and 0x0E00 -> internal path only.
3. External load with ack after 3 wait cycles, ext_rdata=0x12345678 -> ext_req high 4 cycles then 0; cpu_done next cycle with rdata 0x12345678. External store to 0x0B00, wdata=0xCAFE0001 -> ext_we=1, ext_wdata=0xCAFE0001, cpu_rdata unchanged.
4. Timeout: TIMEOUT=16, external request to 0x0C00, ext_ack held 0 -> ext_req drops after 16 cycles in EXT; cpu_done=1, cpu_err=1, cpu_rdata=0. Ack on the final cycle -> cpu_err=0 with the ack data.
5. Back-to-back: cpu_req held high through RESP with a new addr=0x0100 -> second internal access accepted at the IDLE edge immediately after RESP; exactly one cpu_done per transaction.
6. Reset mid-EXT: assert rst during wait cycle 2 -> ext_req and all outputs 0 asynchronously; after release, state is IDLE and a new internal load completes normally.
